// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive front-end.
// Latency: none (declarations only).
// Backpressure: not applicable.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_t;

    // Smallest bit period that still leaves room for a mid-bit sample point.
    localparam int DIV_MIN = 8;

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead byte FIFO buffering received UART bytes for the consumer.
// Latency: a push is visible at head_dat/count the cycle after it is accepted.
// Backpressure: push is ignored when full unless a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_vld,
    input  logic [7:0]               push_dat,
    input  logic                     pop_rdy,
    output logic [7:0]               head_dat,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_q;
    logic          empty;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_rdy && !empty;
    // A full FIFO still takes a byte when the head leaves in the same cycle.
    assign do_push = push_vld && (!full || do_pop);
    assign count   = count_q;
    // Hold the output at zero while empty so the port has a defined value.
    assign head_dat = empty ? 8'h00 : mem[rd_ptr];

    // Pointer and occupancy tracking; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; no reset needed since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/uart_rx_frontend.sv
// UART 8N1 receiver: synchronizes rx_i, reassembles bytes, buffers them for the UDM.
// Latency: ~3 + div/2 + 9*div + 1 cycles from start edge to rx_valid_o.
// Backpressure: rx_ready_i pops the FIFO; a byte arriving into a full FIFO is dropped (overrun_o).
import uart_rx_pkg::*;

module uart_rx_frontend #(
    parameter int DIV_WIDTH  = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [DIV_WIDTH-1:0] divider_i,
    input  logic                 rx_i,
    output logic [7:0]           rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic                 frame_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
);

    localparam logic [DIV_WIDTH-1:0] DIV_FLOOR = DIV_WIDTH'(DIV_MIN);

    logic                       rx_m;
    logic                       rx_s;
    logic                       rx_d;
    rx_state_t                  state;
    logic [DIV_WIDTH-1:0]       div_q;
    logic [DIV_WIDTH-1:0]       cnt;
    logic [2:0]                 bit_cnt;
    logic [7:0]                 shift_q;
    logic                       frame_err_q;
    logic                       overrun_q;
    logic                       cnt_mid;
    logic                       cnt_end;
    logic [DIV_WIDTH-1:0]       div_sel;
    logic                       push_vld;
    logic                       pop_rdy;
    logic                       fifo_full;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    // Out-of-range dividers are floored so a mid-bit sample point always exists.
    assign div_sel  = (divider_i < DIV_FLOOR) ? DIV_FLOOR : divider_i;
    assign cnt_mid  = (cnt == (div_q >> 1));
    assign cnt_end  = (cnt == div_q - DIV_WIDTH'(1));
    assign push_vld = (state == ST_STOP) && cnt_end && rx_s;
    assign pop_rdy  = rx_valid_o && rx_ready_i;

    assign rx_valid_o  = (fifo_count != '0);
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;
    assign busy_o      = (state != ST_IDLE);

    // Two-stage synchronizer plus one delay stage for falling-edge detection; idle high.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= rx_i;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    // Receiver FSM: start validation, LSB-first data shift, stop check, break wait.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= ST_IDLE;
            div_q       <= DIV_FLOOR;
            cnt         <= '0;
            bit_cnt     <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rx_d && !rx_s) begin
                        div_q <= div_sel;
                        cnt   <= '0;
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (cnt_mid) begin
                        if (rx_s) begin
                            state <= ST_IDLE;
                        end else begin
                            cnt     <= '0;
                            bit_cnt <= '0;
                            state   <= ST_DATA;
                        end
                    end else begin
                        cnt <= cnt + DIV_WIDTH'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt_end) begin
                        shift_q <= {rx_s, shift_q[7:1]};
                        cnt     <= '0;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= ST_STOP;
                    end else begin
                        cnt <= cnt + DIV_WIDTH'(1);
                    end
                end
                ST_STOP: begin
                    if (cnt_end) begin
                        cnt <= '0;
                        // Returning to IDLE mid-stop leaves half a bit to catch the next start edge.
                        if (rx_s) begin
                            state <= ST_IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state       <= ST_BREAK;
                        end
                    end else begin
                        cnt <= cnt + DIV_WIDTH'(1);
                    end
                end
                ST_BREAK: begin
                    if (rx_s) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Overrun pulse: completed byte met a full FIFO with no simultaneous pop.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= push_vld && fifo_full && !pop_rdy;
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk_i),
        .rst_n    (rst_n_i),
        .push_vld (push_vld),
        .push_dat (shift_q),
        .pop_rdy  (pop_rdy),
        .head_dat (rx_data_o),
        .full     (fifo_full),
        .count    (fifo_count)
    );

endmodule
